// File: rtl/burst_addr_sched.sv
// Two-requester round-robin burst address generator.
// Optional abort input is built in when BURST_ADDR_SCHED_ABORT_EN is defined.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req[1:0]        level burst request (bit0 = R0, bit1 = R1)
//   base0/base1     burst start address per requester
//   len0/len1       burst beats minus one per requester
//   abort           (BURST_ADDR_SCHED_ABORT_EN only) end current burst now
//   grant[1:0]      one-hot owner of the address stream, 0 when idle
//   addr            current beat address
//   addr_valid      addr is valid this cycle
//   addr_ready      downstream accepts addr this cycle
//   done[1:0]       one-cycle completion pulse per requester
//   busy            high whenever not idle
module burst_addr_sched #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [W-1:0] base0,
  input  logic [W-1:0] base1,
  input  logic [W-1:0] len0,
  input  logic [W-1:0] len1,
`ifdef BURST_ADDR_SCHED_ABORT_EN
  input  logic         abort,
`endif
  output logic [1:0]   grant,
  output logic [W-1:0] addr,
  output logic         addr_valid,
  input  logic         addr_ready,
  output logic [1:0]   done,
  output logic         busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]   r_state;
  logic [1:0]   r_grant;
  logic [W-1:0] r_addr;
  logic [W-1:0] r_cnt;
  logic [W-1:0] r_lim;
  logic         r_rr;
  logic         w_win1;

  // r_rr = 1 means R1 wins a tie
  assign w_win1 = (req == 2'b10) ||
                  (req == 2'b11 && r_rr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_grant <= 2'b00;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_lim   <= '0;
      r_rr    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (req != 2'b00) begin
            r_grant <= w_win1 ? 2'b10 : 2'b01;
            r_addr  <= w_win1 ? base1 : base0;
            r_lim   <= w_win1 ? len1 : len0;
            r_cnt   <= '0;
            r_state <= S_BURST;
          end
        end
        S_BURST: begin
`ifdef BURST_ADDR_SCHED_ABORT_EN
          if (abort) begin
            r_state <= S_DONE;
          end else
`endif
          if (addr_ready) begin
            if (r_cnt == r_lim) begin
              r_state <= S_DONE;
            end else begin
              r_addr <= W'(r_addr + 1'b1);
              r_cnt  <= W'(r_cnt + 1'b1);
            end
          end
        end
        S_DONE: begin
          // hand priority to whoever did not own this burst
          r_rr    <= r_grant[0];
          r_grant <= 2'b00;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant      = r_grant;
  assign addr       = r_addr;
  assign addr_valid = (r_state == S_BURST);
  assign done       = (r_state == S_DONE) ? r_grant : 2'b00;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_burst_addr_sched.sv
// Scoreboard bench for burst_addr_sched.
// Reference model predicts winner and beat list per grant.
module tb_burst_addr_sched;

  typedef struct {
    logic [1:0] own;
    logic [3:0] a;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [3:0] base0 = '0, base1 = '0;
  logic [3:0] len0 = '0, len1 = '0;
  logic       abort_tb = 1'b0;
  logic [1:0] grant;
  logic [3:0] addr;
  logic       addr_valid;
  logic       addr_ready = 1'b1;
  logic [1:0] done;
  logic       busy;

  int n_checks = 0;
  int n_err = 0;

  beat_t      exp_q[$];
  logic [1:0] done_q[$];
  bit         m_rr = 1'b0;

  burst_addr_sched #(.W(4)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .base0(base0),
    .base1(base1),
    .len0(len0),
    .len1(len1),
`ifdef BURST_ADDR_SCHED_ABORT_EN
    .abort(abort_tb),
`endif
    .grant(grant),
    .addr(addr),
    .addr_valid(addr_valid),
    .addr_ready(addr_ready),
    .done(done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // monitor: samples on the falling edge, inputs change after rise
  initial begin
    forever begin
      @(negedge clk);
      if (rst || abort_tb) continue;
      if (addr_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", int'(addr), -1);
        end else begin
          chk("beat_addr", int'(addr), int'(exp_q[0].a));
          chk("beat_grant", int'(grant), int'(exp_q[0].own));
          if (addr_ready) void'(exp_q.pop_front());
        end
      end else if (done != 2'b00) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", int'(done), 0);
        end else begin
          chk("done_owner", int'(done), int'(done_q.pop_front()));
          chk("done_grant", int'(grant), int'(done));
          chk("beats_left_at_done", exp_q.size(), 0);
        end
      end else if (!busy) begin
        chk("idle_grant", int'(grant), 0);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic run_burst(
    input logic [1:0] rq,
    input logic [3:0] b0, input logic [3:0] l0,
    input logic [3:0] b1, input logic [3:0] l1,
    input int rmode, input bit noise,
    input int rst_at, input int abort_at);
    bit win;
    logic [1:0] own;
    logic [3:0] b, l;
    int nb, c;
    wait_idle();
    req = rq;
    base0 = b0; len0 = l0;
    base1 = b1; len1 = l1;
    if (rq != 2'b00) begin
      win = (rq == 2'b11) ? m_rr : (rq == 2'b10);
      own = win ? 2'b10 : 2'b01;
      b = win ? b1 : b0;
      l = win ? l1 : l0;
      nb = (abort_at >= 0) ? abort_at : int'(l) + 1;
      for (int i = 0; i < nb; i++)
        exp_q.push_back('{own, 4'(int'(b) + i)});
      if (rst_at < 0) begin
        done_q.push_back(own);
        m_rr = !win;
      end
    end
    @(posedge clk); #1;
    if (rq == 2'b00) return;
    c = 0;
    while (c < 300) begin
      case (rmode)
        0: addr_ready = 1'b1;
        1: addr_ready = ($urandom_range(0, 3) != 0);
        default: addr_ready = !(c >= 2 && c <= 4);
      endcase
      if (noise) begin
        req = 2'($urandom);
        base0 = 4'($urandom); len0 = 4'($urandom);
        base1 = 4'($urandom); len1 = 4'($urandom);
      end
      abort_tb = (c == abort_at);
      if (c == rst_at) rst = 1'b1;
      @(posedge clk); #1;
      abort_tb = 1'b0;
      if (rst) begin
        rst = 1'b0;
        exp_q.delete();
        done_q.delete();
        m_rr = 1'b0;
        chk("rst_grant", int'(grant), 0);
        chk("rst_addr", int'(addr), 0);
        chk("rst_valid", int'(addr_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        return;
      end
      c++;
      if (!busy) break;
    end
    addr_ready = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_grant", int'(grant), 0);
    chk("reset_addr", int'(addr), 0);
    chk("reset_valid", int'(addr_valid), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_busy", int'(busy), 0);

    // single R0 burst: 3,4,5
    run_burst(2'b01, 4'd3, 4'd2, 4'd0, 4'd0, 0, 0, -1, -1);
    // R1 burst wrapping 14,15,0,1
    run_burst(2'b10, 4'd0, 4'd0, 4'd14, 4'd3, 0, 0, -1, -1);
    // held contention alternates 01,10,01
    for (int k = 0; k < 3; k++)
      run_burst(2'b11, 4'd1, 4'd1, 4'd9, 4'd2, 0, 0, -1, -1);
    // stall on beat 2 for 3 cycles
    run_burst(2'b01, 4'd5, 4'd4, 4'd0, 4'd0, 2, 0, -1, -1);
    // reset at beat 1 of an R1 burst, then tie must go to R0
    run_burst(2'b10, 4'd0, 4'd0, 4'd7, 4'd3, 0, 0, 1, -1);
    run_burst(2'b11, 4'd12, 4'd1, 4'd2, 4'd1, 0, 0, -1, -1);
`ifdef BURST_ADDR_SCHED_ABORT_EN
    // abort on beat 1 of a 4-beat burst
    run_burst(2'b01, 4'd2, 4'd3, 4'd0, 4'd0, 0, 0, -1, 1);
    run_burst(2'b10, 4'd0, 4'd0, 4'd6, 4'd3, 1, 1, -1, 0);
`endif
    for (int k = 0; k < 150; k++)
      run_burst(2'($urandom),
                4'($urandom), 4'($urandom),
                4'($urandom), 4'($urandom),
                1, 1, -1, -1);
    req = 2'b00;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("final_beats_left", exp_q.size(), 0);
    chk("final_dones_left", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
